change_dispenser: RTL and testbench

Sequencing controller for the vending machine's coin-return hopper. It accepts a change amount from the vending FSM's checkout step over a valid/ready handshake. It pays the amount out one coin at a time, largest denomination first, from a tracked per-denomination inventory. It reports completion, and a shortfall when the inventory cannot cover the amount.

---
 rtl/vm_pkg.sv | 31 +++
 rtl/change_coin_pick.sv | 47 ++++
 rtl/change_dispenser.sv | 204 ++++++++++++++++++++
 tb/tb_change_dispenser.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// ---------------------------------------------------------------------------
// vm_pkg
// Shared vending-machine definitions: coin denomination codes, drink prices
// used by the vending FSM, and the change dispenser state encoding.
// No ports; imported by the dispenser and its coin picker.
// ---------------------------------------------------------------------------
package vm_pkg;

  localparam int COIN_W = 8;

  // Denomination codes; the code equals the coin value
  localparam logic [COIN_W-1:0] COIN_NONE = 8'd0;
  localparam logic [COIN_W-1:0] COIN_1    = 8'd1;
  localparam logic [COIN_W-1:0] COIN_5    = 8'd5;
  localparam logic [COIN_W-1:0] COIN_10   = 8'd10;
  localparam logic [COIN_W-1:0] COIN_50   = 8'd50;

  // Drink prices, shared with the vending FSM checkout step
  localparam logic [COIN_W-1:0] PRICE_WATER = 8'd35;
  localparam logic [COIN_W-1:0] PRICE_SODA  = 8'd65;
  localparam logic [COIN_W-1:0] PRICE_JUICE = 8'd85;

  // Change dispenser sequencing states
  typedef enum logic [1:0] {
    DISP_IDLE   = 2'd0,
    DISP_SELECT = 2'd1,
    DISP_ISSUE  = 2'd2,
    DISP_FIN    = 2'd3
  } disp_state_e;

endpackage

// File: rtl/change_coin_pick.sv
// ---------------------------------------------------------------------------
// change_coin_pick
// Combinational greedy selector: the largest denomination that both fits in
// the outstanding balance and is still in stock.
//   remaining_i          balance still to pay
//   cnt_{50,10,5,1}_i    current inventory per denomination
//   coin_o               chosen denomination (COIN_NONE when none fits)
//   none_o               1 when no denomination qualifies (also when
//                        remaining_i is zero)
// ---------------------------------------------------------------------------
module change_coin_pick
  import vm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic [COIN_W-1:0] remaining_i,
  input  logic [CNT_W-1:0]  cnt_50_i,
  input  logic [CNT_W-1:0]  cnt_10_i,
  input  logic [CNT_W-1:0]  cnt_5_i,
  input  logic [CNT_W-1:0]  cnt_1_i,
  output logic [COIN_W-1:0] coin_o,
  output logic              none_o
);

  // Priority chain from the largest denomination down
  always_comb begin
    coin_o = COIN_NONE;
    none_o = 1'b1;
    if ((cnt_50_i != {CNT_W{1'b0}}) && (remaining_i >= COIN_50)) begin
      coin_o = COIN_50;
      none_o = 1'b0;
    end else if ((cnt_10_i != {CNT_W{1'b0}}) && (remaining_i >= COIN_10)) begin
      coin_o = COIN_10;
      none_o = 1'b0;
    end else if ((cnt_5_i != {CNT_W{1'b0}}) && (remaining_i >= COIN_5)) begin
      coin_o = COIN_5;
      none_o = 1'b0;
    end else if ((cnt_1_i != {CNT_W{1'b0}}) && (remaining_i >= COIN_1)) begin
      coin_o = COIN_1;
      none_o = 1'b0;
    end else begin
      coin_o = COIN_NONE;
      none_o = 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
// Coin-return hopper sequencer. Accepts a change amount, pays it out one coin
// at a time (largest denomination first) from a tracked inventory, and
// reports completion plus a shortfall flag.
//   clk, reset                 clock, synchronous active-low reset
//   req_valid/req_amount/      change request handshake (ready only in IDLE)
//   req_ready
//   refill_valid/refill_coin   one coin loaded into the hopper this cycle
//   coin_valid/coin_out/       coin presented to the hopper, held until ack
//   coin_ack
//   done/short/remaining       end-of-payout pulse, shortfall, unpaid balance
//   cnt_50/10/5/1              current inventory
// ---------------------------------------------------------------------------
module change_dispenser
  import vm_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int INIT_50 = 4,
  parameter int INIT_10 = 5,
  parameter int INIT_5  = 5,
  parameter int INIT_1  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [7:0]        req_amount,
  output logic              req_ready,
  input  logic              refill_valid,
  input  logic [7:0]        refill_coin,
  output logic              coin_valid,
  output logic [7:0]        coin_out,
  input  logic              coin_ack,
  output logic              done,
  output logic              short,
  output logic [7:0]        remaining,
  output logic [CNT_W-1:0]  cnt_50,
  output logic [CNT_W-1:0]  cnt_10,
  output logic [CNT_W-1:0]  cnt_5,
  output logic [CNT_W-1:0]  cnt_1
);

  // Inventory slot order: 0 = 50, 1 = 10, 2 = 5, 3 = 1
  localparam logic [3:0][COIN_W-1:0] DENOM  = {COIN_1, COIN_5, COIN_10, COIN_50};
  localparam logic [3:0][CNT_W-1:0]  INIT_V = {CNT_W'(INIT_1), CNT_W'(INIT_5),
                                               CNT_W'(INIT_10), CNT_W'(INIT_50)};
  localparam logic [CNT_W-1:0]       CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]       CNT_ONE = CNT_W'(1);

  disp_state_e              state_q, state_d;
  logic [COIN_W-1:0]        remaining_q, remaining_d;
  logic [COIN_W-1:0]        coin_out_q, coin_out_d;
  logic                     coin_valid_q, coin_valid_d;
  logic                     short_q, short_d;
  logic [3:0][CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]               inc_s, dec_s;
  logic                     ack_s;
  logic [COIN_W-1:0]        pick_coin_s;
  logic                     pick_none_s;

  // Next counter value. A simultaneous refill and eject cancel, except at
  // saturation where the refill was already lost and the eject still counts.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc,
                                                input logic dec);
    logic [CNT_W-1:0] nxt;
    if (inc && dec) begin
      if (cnt == CNT_MAX) begin
        nxt = cnt - CNT_ONE;
      end else begin
        nxt = cnt;
      end
    end else if (inc) begin
      if (cnt == CNT_MAX) begin
        nxt = cnt;
      end else begin
        nxt = cnt + CNT_ONE;
      end
    end else if (dec) begin
      nxt = cnt - CNT_ONE;
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

  change_coin_pick #(
    .CNT_W (CNT_W)
  ) u_pick (
    .remaining_i (remaining_q),
    .cnt_50_i    (cnt_q[0]),
    .cnt_10_i    (cnt_q[1]),
    .cnt_5_i     (cnt_q[2]),
    .cnt_1_i     (cnt_q[3]),
    .coin_o      (pick_coin_s),
    .none_o      (pick_none_s)
  );

  // An ack only counts while a coin is actually being presented
  assign ack_s = (state_q == DISP_ISSUE) && coin_ack;

  for (genvar g = 0; g < 4; g++) begin : g_slot
    assign inc_s[g] = refill_valid && (refill_coin == DENOM[g]);
    assign dec_s[g] = ack_s && (coin_out_q == DENOM[g]);
  end

  // Inventory next-state for all four denominations
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_next(cnt_q[i], inc_s[i], dec_s[i]);
    end
  end

  // Sequencer next-state and datapath updates
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    coin_out_d   = coin_out_q;
    coin_valid_d = coin_valid_q;
    short_d      = short_q;
    case (state_q)
      DISP_IDLE: begin
        if (req_valid) begin
          remaining_d = req_amount;
          short_d     = 1'b0;
          state_d     = DISP_SELECT;
        end else begin
          state_d = DISP_IDLE;
        end
      end
      DISP_SELECT: begin
        if (remaining_q == 8'd0) begin
          short_d = 1'b0;
          state_d = DISP_FIN;
        end else if (pick_none_s) begin
          short_d = 1'b1;
          state_d = DISP_FIN;
        end else begin
          coin_out_d   = pick_coin_s;
          coin_valid_d = 1'b1;
          state_d      = DISP_ISSUE;
        end
      end
      DISP_ISSUE: begin
        if (coin_ack) begin
          // SELECT only picks coins <= remaining, so this cannot underflow
          remaining_d  = remaining_q - coin_out_q;
          coin_out_d   = COIN_NONE;
          coin_valid_d = 1'b0;
          state_d      = DISP_SELECT;
        end else begin
          state_d = DISP_ISSUE;
        end
      end
      DISP_FIN: begin
        state_d = DISP_IDLE;
      end
      default: begin
        state_d      = DISP_IDLE;
        coin_out_d   = COIN_NONE;
        coin_valid_d = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= DISP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and inventory registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      remaining_q  <= 8'd0;
      coin_out_q   <= COIN_NONE;
      coin_valid_q <= 1'b0;
      short_q      <= 1'b0;
      cnt_q        <= INIT_V;
    end else begin
      remaining_q  <= remaining_d;
      coin_out_q   <= coin_out_d;
      coin_valid_q <= coin_valid_d;
      short_q      <= short_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ready  = (state_q == DISP_IDLE);
  assign done       = (state_q == DISP_FIN);
  assign short      = short_q;
  assign remaining  = remaining_q;
  assign coin_valid = coin_valid_q;
  assign coin_out   = coin_out_q;
  assign cnt_50     = cnt_q[0];
  assign cnt_10     = cnt_q[1];
  assign cnt_5      = cnt_q[2];
  assign cnt_1      = cnt_q[3];

endmodule

// File: tb/tb_change_dispenser.sv
// ---------------------------------------------------------------------------
// tb_change_dispenser
// Directed bench for change_dispenser with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_change_dispenser;
  import vm_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [7:0] req_amount;
  logic       req_ready;
  logic       refill_valid;
  logic [7:0] refill_coin;
  logic       coin_valid;
  logic [7:0] coin_out;
  logic       coin_ack;
  logic       done;
  logic       short;
  logic [7:0] remaining;
  logic [7:0] cnt_50, cnt_10, cnt_5, cnt_1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] seen_q[$];
  logic [7:0] exp_q[$];
  logic       got_done;
  logic       last_short;
  logic [7:0] last_rem;
  int         done_cyc;
  int         first_cyc;
  logic       saw_done;

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_amount   (req_amount),
    .req_ready    (req_ready),
    .refill_valid (refill_valid),
    .refill_coin  (refill_coin),
    .coin_valid   (coin_valid),
    .coin_out     (coin_out),
    .coin_ack     (coin_ack),
    .done         (done),
    .short        (short),
    .remaining    (remaining),
    .cnt_50       (cnt_50),
    .cnt_10       (cnt_10),
    .cnt_5        (cnt_5),
    .cnt_1        (cnt_1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_cnts(input string tag, input int e50, input int e10,
                            input int e5, input int e1);
    check_eq({tag, "_c50"}, 32'(cnt_50), 32'(e50));
    check_eq({tag, "_c10"}, 32'(cnt_10), 32'(e10));
    check_eq({tag, "_c5"},  32'(cnt_5),  32'(e5));
    check_eq({tag, "_c1"},  32'(cnt_1),  32'(e1));
  endtask

  // Called at a falling edge; one rising edge passes with reset low
  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Called at a falling edge while idle; returns at the falling edge of the
  // SELECT cycle (T+1)
  task automatic send_req(input string tag, input logic [7:0] amt);
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_amount = amt;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  // Records presented coins until done; cycle index 0 is the SELECT cycle
  task automatic collect(input string tag, input int budget);
    seen_q.delete();
    got_done  = 1'b0;
    done_cyc  = -1;
    first_cyc = -1;
    for (int c = 0; c < budget && !got_done; c++) begin
      if (coin_valid) begin
        if (first_cyc < 0) first_cyc = c;
        seen_q.push_back(coin_out);
      end
      if (done) begin
        got_done   = 1'b1;
        done_cyc   = c;
        last_short = short;
        last_rem   = remaining;
      end else begin
        @(negedge clk);
      end
    end
    check_eq({tag, "_done_seen"}, 32'(got_done), 32'd1);
    @(negedge clk);
  endtask

  // Expected coin list packed first-coin-in-the-top-byte, n coins
  task automatic set_exp(input int n, input logic [63:0] v);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(v[8*(n-1-i) +: 8]);
  endtask

  task automatic pay(input string tag, input logic [7:0] amt, input int n,
                     input logic [63:0] v, input logic exp_short, input logic [7:0] exp_rem);
    set_exp(n, v);
    send_req(tag, amt);
    collect(tag, 60);
    check_eq({tag, "_ncoins"}, 32'(seen_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
      check_eq($sformatf("%s_coin%0d", tag, i), 32'(seen_q[i]), 32'(exp_q[i]));
    end
    check_eq({tag, "_short"}, 32'(last_short), 32'(exp_short));
    check_eq({tag, "_rem"},   32'(last_rem),   32'(exp_rem));
  endtask

  initial begin
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_amount   = 8'd0;
    refill_valid = 1'b0;
    refill_coin  = 8'd0;
    coin_ack     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Reset state
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_cv",    32'(coin_valid), 32'd0);
    check_eq("rst_cout",  32'(coin_out), 32'd0);
    check_eq("rst_done",  32'(done), 32'd0);
    check_eq("rst_short", 32'(short), 32'd0);
    check_eq("rst_rem",   32'(remaining), 32'd0);
    check_cnts("rst", 4, 5, 5, 10);

    // Greedy payout with full inventory
    pay("greedy", 8'd37, 6, {8'd10, 8'd10, 8'd10, 8'd5, 8'd1, 8'd1}, 1'b0, 8'd0);
    check_eq("greedy_first_cyc", 32'(first_cyc), 32'd1);
    check_eq("greedy_done_cyc",  32'(done_cyc),  32'd13);
    check_cnts("greedy", 4, 2, 4, 8);

    // Zero amount: done two cycles after acceptance, no coin
    pay("zero", 8'd0, 0, 64'd0, 1'b0, 8'd0);
    check_eq("zero_done_cyc", 32'(done_cyc), 32'd1);
    check_eq("zero_ready_after", 32'(req_ready), 32'd1);

    // Denomination fallback: leave one 10-coin, then pay 37
    do_reset();
    pay("drain10", 8'd40, 4, {8'd10, 8'd10, 8'd10, 8'd10}, 1'b0, 8'd0);
    check_eq("drain10_c10", 32'(cnt_10), 32'd1);
    pay("fallback", 8'd37, 8, {8'd10, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd1, 8'd1}, 1'b0, 8'd0);
    check_cnts("fallback", 4, 0, 0, 8);

    // Shortfall: drain to 50:0 10:0 5:0 1:2, then pay 5
    pay("drain50", 8'd200, 4, {8'd50, 8'd50, 8'd50, 8'd50}, 1'b0, 8'd0);
    pay("drain1", 8'd6, 6, {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 1'b0, 8'd0);
    check_cnts("drained", 0, 0, 0, 2);
    pay("short", 8'd5, 2, {8'd1, 8'd1}, 1'b1, 8'd3);
    check_eq("short_done_cyc", 32'(done_cyc), 32'd5);
    check_eq("short_c1", 32'(cnt_1), 32'd0);

    // Ack held low: coin stays presented, nothing changes until ack
    do_reset();
    coin_ack = 1'b0;
    send_req("hold", 8'd10);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("hold_cv%0d", k),   32'(coin_valid), 32'd1);
      check_eq($sformatf("hold_cout%0d", k), 32'(coin_out),   32'd10);
      check_eq($sformatf("hold_rem%0d", k),  32'(remaining),  32'd10);
      check_eq($sformatf("hold_c10_%0d", k), 32'(cnt_10),     32'd5);
      @(negedge clk);
    end
    // Ack together with a refill of the same denomination
    coin_ack     = 1'b1;
    refill_valid = 1'b1;
    refill_coin  = 8'd10;
    @(negedge clk);
    refill_valid = 1'b0;
    check_eq("hold_ack_c10", 32'(cnt_10),     32'd5);
    check_eq("hold_ack_rem", 32'(remaining),  32'd0);
    check_eq("hold_ack_cv",  32'(coin_valid), 32'd0);
    collect("hold", 20);
    check_eq("hold_short", 32'(last_short), 32'd0);

    // Saturation of the 1-coin counter
    do_reset();
    refill_valid = 1'b1;
    refill_coin  = 8'd1;
    for (int k = 0; k < 245; k++) @(negedge clk);
    check_eq("sat_reach", 32'(cnt_1), 32'd255);
    for (int k = 0; k < 3; k++) @(negedge clk);
    check_eq("sat_hold", 32'(cnt_1), 32'd255);
    // Unknown denomination is ignored
    refill_coin = 8'd7;
    @(negedge clk);
    @(negedge clk);
    refill_valid = 1'b0;
    check_cnts("bad_coin", 4, 5, 5, 255);
    // Refill 50 is counted
    refill_valid = 1'b1;
    refill_coin  = 8'd50;
    @(negedge clk);
    refill_valid = 1'b0;
    check_eq("refill50", 32'(cnt_50), 32'd5);
    // Saturated counter with refill and eject in the same cycle drops by 1
    send_req("satdec", 8'd1);
    @(negedge clk);
    check_eq("satdec_cout", 32'(coin_out), 32'd1);
    refill_valid = 1'b1;
    refill_coin  = 8'd1;
    @(negedge clk);
    refill_valid = 1'b0;
    check_eq("satdec_c1", 32'(cnt_1), 32'd254);
    collect("satdec", 20);
    check_eq("satdec_short", 32'(last_short), 32'd0);

    // Reset in the middle of an issue
    coin_ack = 1'b0;
    send_req("midrst", 8'd37);
    @(negedge clk);
    check_eq("midrst_cv_before", 32'(coin_valid), 32'd1);
    do_reset();
    check_eq("midrst_cv",    32'(coin_valid), 32'd0);
    check_eq("midrst_ready", 32'(req_ready),  32'd1);
    check_eq("midrst_rem",   32'(remaining),  32'd0);
    check_eq("midrst_done",  32'(done),       32'd0);
    check_cnts("midrst", 4, 5, 5, 10);
    coin_ack = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    check_eq("midrst_no_done", 32'(saw_done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
